// File: rtl/aes_round_sequencer_if.sv
// Handshake and sequencing bus between the AES round sequencer and its
// controller / key expansion. The controller side uses the master modport,
// the sequencer itself uses the slave modport.
interface aes_round_sequencer_if;
  logic       start;
  logic       abort;
  logic       enc_dec;
  logic [4:0] state_counter;
  logic [7:0] rcon;
  logic       en_signal;
  logic [3:0] round_idx;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output abort,
    output enc_dec,
    input  state_counter,
    input  rcon,
    input  en_signal,
    input  round_idx,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  abort,
    input  enc_dec,
    output state_counter,
    output rcon,
    output en_signal,
    output round_idx,
    output busy,
    output done
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// AES round sequencer: walks 11 rounds of 20 intra-round steps each and
// produces the step code, the round constant and the round index.
// Optional feature: define AES_SEQ_HOLD_EN to add a 'hold' input that freezes
// the sequence for one cycle per held cycle while running.
//
// state | meaning
// IDLE  | waiting for start; outputs at idle values
// RUN   | advancing one step per cycle (220 cycles without hold)
// DONE  | one-cycle completion pulse, then back to IDLE
module aes_round_sequencer (
  input  logic clk,
  input  logic rst,
`ifdef AES_SEQ_HOLD_EN
  input  logic hold,
`endif
  aes_round_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [4:0] LAST_STEP  = 5'd19;
  localparam logic [3:0] LAST_ROUND = 4'd11;
  localparam logic [7:0] RCON_ENC0  = 8'h01;
  localparam logic [7:0] RCON_DEC0  = 8'h6C;
  localparam logic [7:0] RCON_IDLE  = 8'h01;

  state_e     state_q, state_d;
  logic [4:0] step_q, step_d;
  logic [3:0] round_q, round_d;
  logic [7:0] rcon_q, rcon_d;
  logic       mode_q, mode_d;
  logic       hold_w;

`ifdef AES_SEQ_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // Step index -> step code. The default keeps the output off zero even if
  // the index were ever corrupted.
  function automatic logic [4:0] step_code(input logic [4:0] idx);
    logic [4:0] code;
    case (idx)
      5'd0:    code = 5'd1;
      5'd1:    code = 5'd3;
      5'd2:    code = 5'd7;
      5'd3:    code = 5'd15;
      5'd4:    code = 5'd31;
      5'd5:    code = 5'd30;
      5'd6:    code = 5'd29;
      5'd7:    code = 5'd26;
      5'd8:    code = 5'd21;
      5'd9:    code = 5'd10;
      5'd10:   code = 5'd20;
      5'd11:   code = 5'd9;
      5'd12:   code = 5'd19;
      5'd13:   code = 5'd6;
      5'd14:   code = 5'd12;
      5'd15:   code = 5'd24;
      5'd16:   code = 5'd17;
      5'd17:   code = 5'd2;
      5'd18:   code = 5'd4;
      5'd19:   code = 5'd8;
      default: code = 5'd1;
    endcase
    return code;
  endfunction

  // Encrypt walks rcon forward with xtime; decrypt walks it backwards with
  // the inverse of xtime, so both directions share one register.
  function automatic logic [7:0] rcon_next(input logic [7:0] r, input logic enc);
    logic [7:0] nxt;
    if (enc) begin
      nxt = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    end else begin
      nxt = r[0] ? (((r ^ 8'h1B) >> 1) | 8'h80) : (r >> 1);
    end
    return nxt;
  endfunction

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      step_q  <= 5'd0;
      round_q <= 4'd0;
      rcon_q  <= RCON_IDLE;
      mode_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      round_q <= round_d;
      rcon_q  <= rcon_d;
      mode_q  <= mode_d;
    end
  end

  // Next-state logic; leaving RUN always restores the idle register values.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    round_d = round_q;
    rcon_d  = rcon_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        // abort wins over a simultaneous start
        if (bus.start && !bus.abort) begin
          state_d = RUN;
          step_d  = 5'd0;
          round_d = 4'd1;
          mode_d  = bus.enc_dec;
          rcon_d  = bus.enc_dec ? RCON_ENC0 : RCON_DEC0;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          step_d  = 5'd0;
          round_d = 4'd0;
          rcon_d  = RCON_IDLE;
        end else if (!hold_w) begin
          if (step_q == LAST_STEP) begin
            if (round_q == LAST_ROUND) begin
              state_d = DONE;
              step_d  = 5'd0;
              round_d = 4'd0;
              rcon_d  = RCON_IDLE;
            end else begin
              step_d  = 5'd0;
              round_d = round_q + 4'd1;
              rcon_d  = rcon_next(rcon_q, mode_q);
            end
          end else begin
            step_d = step_q + 5'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        step_d  = 5'd0;
        round_d = 4'd0;
        rcon_d  = RCON_IDLE;
      end
    endcase
  end

  // Outputs; the idle register values already produce the idle output set.
  assign bus.state_counter = step_code(step_q);
  assign bus.rcon          = rcon_q;
  assign bus.round_idx     = round_q;
  assign bus.busy          = (state_q == RUN);
  assign bus.en_signal     = (state_q == RUN) && !hold_w;
  assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer. Build with AES_SEQ_HOLD_EN defined
// to also exercise the hold input.
module tb_aes_round_sequencer;

  logic clk;
  logic rst;
  logic hold;
  int   n_cmp;
  int   n_err;

  aes_round_sequencer_if bus_if ();

  aes_round_sequencer dut (
    .clk  (clk),
    .rst  (rst),
`ifdef AES_SEQ_HOLD_EN
    .hold (hold),
`endif
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] codes   [20] = '{5'd1, 5'd3, 5'd7, 5'd15, 5'd31, 5'd30, 5'd29, 5'd26, 5'd21, 5'd10,
                               5'd20, 5'd9, 5'd19, 5'd6, 5'd12, 5'd24, 5'd17, 5'd2, 5'd4, 5'd8};
  logic [7:0] enc_tbl [11] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36, 8'h6C};
  logic [7:0] dec_tbl [11] = '{8'h6C, 8'h36, 8'h1B, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

  // {busy, en_signal, done, state_counter, round_idx, rcon}
  localparam logic [19:0] IDLE_VEC = {3'b000, 5'd1, 4'd0, 8'h01};
  localparam logic [19:0] DONE_VEC = {3'b001, 5'd1, 4'd0, 8'h01};

  function automatic logic [19:0] outs();
    return {bus_if.busy, bus_if.en_signal, bus_if.done, bus_if.state_counter,
            bus_if.round_idx, bus_if.rcon};
  endfunction

  // Launch an operation: start is captured at the next edge, and the
  // observation point #1 after that edge is step index 0.
  task automatic launch(input bit enc);
    bus_if.enc_dec = enc;
    bus_if.start   = 1'b1;
    @(posedge clk); #1;
    bus_if.start   = 1'b0;
  endtask

  // Walks a whole operation against the reference tables, optionally
  // re-asserting start (with the opposite mode) at one step and holding at
  // another. Every cycle through the idle cycle after done is compared.
  task automatic walk(input string name, input bit enc, input int restart_idx,
                      input int hold_idx, input int hold_len);
    int          idx;
    int          held;
    int          done_obs;
    int          rnd;
    bit          hold_now;
    bit          restarted;
    logic [19:0] got;
    logic [19:0] exp_v;
    idx = 0; held = 0; done_obs = -1; restarted = 1'b0;
    launch(enc);
    for (int obs = 0; obs < 240 + hold_len && idx < 222; obs++) begin
      hold_now = (idx == hold_idx) && (held < hold_len);
      hold     = hold_now;
      if (idx == restart_idx && !restarted) begin
        bus_if.start   = 1'b1;
        bus_if.enc_dec = ~enc;
        restarted      = 1'b1;
      end else begin
        bus_if.start   = 1'b0;
        bus_if.enc_dec = enc;
      end
      #1;
      got = outs();
      if (idx < 220) begin
        rnd   = idx / 20;
        exp_v = {1'b1, ~hold_now, 1'b0, codes[idx % 20], 4'(rnd + 1),
                 enc ? enc_tbl[rnd] : dec_tbl[rnd]};
      end else if (idx == 220) begin
        exp_v    = DONE_VEC;
        done_obs = obs;
      end else begin
        exp_v = IDLE_VEC;
      end
      n_cmp++;
      if (got !== exp_v) begin
        n_err++;
        $display("FAIL %s step=%0d obs=%0d got=%h expected=%h", name, idx, obs, got, exp_v);
      end
      if (idx < 220 && hold_now) held++;
      else idx++;
      @(posedge clk); #1;
    end
    hold = 1'b0;
    bus_if.start = 1'b0;
    n_cmp++;
    if (done_obs != 220 + hold_len) begin
      n_err++;
      $display("FAIL %s_done_latency got=%0d expected=%0d", name, done_obs, 220 + hold_len);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_err++;
      $display("FAIL reset got=%h expected=%h", outs(), IDLE_VEC);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_err++;
      $display("FAIL reset_idle_hold got=%h expected=%h", outs(), IDLE_VEC);
    end
  endtask

  task automatic test_encrypt();
    walk("encrypt", 1'b1, -1, -1, 0);
  endtask

  task automatic test_decrypt();
    walk("decrypt", 1'b0, -1, -1, 0);
  endtask

  // start (with the other mode) during round 3 must change nothing
  task automatic test_start_ignored();
    walk("start_ignored", 1'b1, 2 * 20 + 5, -1, 0);
  endtask

  task automatic test_abort();
    logic [19:0] exp_v;
    launch(1'b1);
    repeat (4 * 20 + 7) begin @(posedge clk); #1; end
    exp_v = {3'b110, 5'd26, 4'd5, 8'h10};
    n_cmp++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL abort_position got=%h expected=%h", outs(), exp_v);
    end
    bus_if.abort = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_err++;
      $display("FAIL abort_idle got=%h expected=%h", outs(), IDLE_VEC);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (outs() !== IDLE_VEC) begin
        n_err++;
        $display("FAIL abort_no_done cycle=%0d got=%h expected=%h", i, outs(), IDLE_VEC);
      end
    end
    // abort and start together in RUN: abort wins, no restart
    launch(1'b1);
    repeat (5) begin @(posedge clk); #1; end
    bus_if.abort = 1'b1;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
    bus_if.start = 1'b0;
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_err++;
      $display("FAIL abort_over_start_run got=%h expected=%h", outs(), IDLE_VEC);
    end
    // abort and start together in IDLE: start is not accepted
    bus_if.abort = 1'b1;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
    bus_if.start = 1'b0;
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_err++;
      $display("FAIL abort_over_start_idle got=%h expected=%h", outs(), IDLE_VEC);
    end
    // abort alone in IDLE is harmless: a following start still runs
    bus_if.abort = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
    launch(1'b0);
    exp_v = {3'b110, 5'd1, 4'd1, 8'h6C};
    n_cmp++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL start_after_idle_abort got=%h expected=%h", outs(), exp_v);
    end
    bus_if.abort = 1'b1;
    @(posedge clk); #1;
    bus_if.abort = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [19:0] exp_v;
    launch(1'b0);
    repeat (8 * 20 + 3) begin @(posedge clk); #1; end
    exp_v = {3'b110, 5'd15, 4'd9, 8'h04};
    n_cmp++;
    if (outs() !== exp_v) begin
      n_err++;
      $display("FAIL reset_mid_position got=%h expected=%h", outs(), exp_v);
    end
    rst          = 1'b1;
    bus_if.start = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_err++;
      $display("FAIL reset_mid_run got=%h expected=%h", outs(), IDLE_VEC);
    end
    rst          = 1'b0;
    bus_if.start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (outs() !== IDLE_VEC) begin
      n_err++;
      $display("FAIL reset_mid_run_stays_idle got=%h expected=%h", outs(), IDLE_VEC);
    end
  endtask

`ifdef AES_SEQ_HOLD_EN
  task automatic test_hold();
    walk("hold", 1'b1, -1, 1 * 20 + 10, 3);
  endtask
`endif

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst            = 1'b1;
    hold           = 1'b0;
    bus_if.start   = 1'b0;
    bus_if.abort   = 1'b0;
    bus_if.enc_dec = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_encrypt();
    test_decrypt();
    test_start_ignored();
    test_abort();
    test_reset_mid_run();
`ifdef AES_SEQ_HOLD_EN
    test_hold();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
